image_window_fetch: RTL
=======================

// Module: image_window_fetch
// PURPOSE
//  Downstream reader for the image page RAM: raster-scans a page, one byte per read, through
//  its 1-cycle synchronous read port. Builds 3x3 pixel windows via two line buffers plus a
//  3x3 shift array, and emits each complete window on a valid/ready stream.
//  Feeds the first convolution stage.
// PARAMETERS
//  IMG_W   640  pixels per row (>=3)
//  IMG_H   640  rows per page (>=3); IMG_W*IMG_H <= 2**ADDR_W
//  ADDR_W  25   page address width
//  DATA_W  8    pixel width
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  start      in   1          begin a page scan; ignored while busy
//  busy       out  1          high from the cycle after start until done
//  done       out  1          one-cycle pulse: last window accepted
//  mem_addr   out  ADDR_W     page read address (drives addr1_1)
//  mem_re     out  1          page read enable (drives r_enable); page we is tied 0 at top
//  mem_rdata  in   DATA_W     page read data, valid 1 cycle after mem_re
//  win_valid  out  1          window available
//  win_ready  in   1          consumer accepts window
//  win_data   out  9*DATA_W   [71:64]=top-left ... [7:0]=bottom-right, row-major
//  win_row    out  16         row of window centre
//  win_col    out  16         column of window centre
// BEHAVIOUR
//  - Reset: busy=0, done=0, mem_re=0, mem_addr=0, win_valid=0, win_data=0, win_row=0, win_col=0.
//  - Reset mid-scan: counters and pending window are discarded; the block returns to IDLE.
//    Line buffer contents are don't-care.
//  - FSM:
//    IDLE: start -> SCAN; clears counters.
//    SCAN: last pixel consumed -> DRAIN.
//    DRAIN: win_valid==0, or last window accepted -> IDLE, pulsing done.
//  - Read issue: rd_v = registered mem_re.
//    adv = !win_valid || win_ready.
//    mem_re = SCAN && rd_addr < IMG_W*IMG_H && (!rd_v || adv).
//    mem_addr = rd_addr; rd_addr increments on each mem_re.
//  - Stall: pixel consumed when rd_v && adv. If rd_v && !adv, mem_re=0 and the page's held
//    data_out is reused next cycle; no pixel is lost or duplicated.
//  - Consume (pixel p at r,c; c wraps at IMG_W-1 -> 0, r++):
//    - shift the 3x3 array left;
//    - new right column = {lb1[c], lb0[c], p};
//    - then lb1[c] <= lb0[c], lb0[c] <= p.
//  - Window emitted on consume when r>=2 && c>=2 (no padding):
//    - win_valid=1;
//    - win_row = r-1, win_col = c-1;
//    - win_data = pixels (r-2..r, c-2..c).
//    - Windows per page: (IMG_H-2)*(IMG_W-2).
//  - Window left columns at c=2 never contain pixels of the previous row (array refill is
//    complete by c=2).
//  - win_valid is cleared on accept unless a new window is loaded in the same cycle.
//  - win_data is stable while win_valid && !win_ready.
//  - Throughput: one window/cycle with win_ready=1; first mem_re the cycle after start.
//  - start while busy: ignored. start in the done cycle: accepted (new scan next cycle).
// CONFIGURATION
//  IMG_WIN_STRIDE2_EN:
//  - defined: a window is emitted only when (r-2) and (c-2) are both even (stride-2).
//    Count = ceil((IMG_H-2)/2)*ceil((IMG_W-2)/2). Pixels are still all read.
//  - undefined: stride 1, as above.
// TESTING  (IMG_W=5, IMG_H=4, page preloaded mem[a]=a)
//  1. start, win_ready=1
//     -> 6 windows.
//     -> First: row1 col1, win_data = 00,01,02,05,06,07,0A,0B,0C.
//     -> Last: row2 col3, 07,08,09,0C,0D,0E,11,12,13.
//     -> done pulses once.
//  2. win_ready low for 5 cycles mid-scan
//     -> mem_re=0 while stalled, win_data held, same 6 windows in order, none lost or duplicated.
//  3. rst asserted during SCAN
//     -> next cycle all outputs at reset values.
//     -> New start gives the full 6-window sequence of test 1.
//  4. start pulsed while busy
//     -> ignored; exactly one done, 20 reads total (mem_re high 20 cycles).
//  5. IMG_WIN_STRIDE2_EN defined
//     -> 2 windows: centres (1,1) and (1,3).
//     -> Second win_data = 02,03,04,07,08,09,0C,0D,0E.
//  6. win_ready toggling every cycle
//     -> window order and values match test 1; done only after the 6th accept.

Source files
------------

// File: rtl/image_window_fetch.sv
`default_nettype none
// ============================================================================
// Module  : image_window_fetch
// Purpose : Raster-scans an image page over a 1-cycle synchronous read port
//           and streams 3x3 pixel windows (row-major) on a valid/ready port.
//           Define IMG_WIN_STRIDE2_EN for stride-2 window emission.
// Revision: 1.0  initial release
// ============================================================================
module image_window_fetch #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 640,
   parameter int ADDR_W = 25,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_re,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [9*DATA_W-1:0]   win_data,
   output logic [15:0]           win_row,
   output logic [15:0]           win_col
);

   localparam int              c_CW       = $clog2(IMG_W);
   localparam logic [ADDR_W:0] c_TOTAL    = (ADDR_W+1)'(IMG_W * IMG_H);
   localparam logic [15:0]     c_LAST_COL = 16'(IMG_W - 1);
   localparam logic [15:0]     c_LAST_ROW = 16'(IMG_H - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_done_nxt;

   logic [ADDR_W:0]     r_rd_addr;
   logic                r_rd_v;
   logic [15:0]         r_row;
   logic [15:0]         r_col;

   logic [DATA_W-1:0]   r_lb0 [IMG_W];
   logic [DATA_W-1:0]   r_lb1 [IMG_W];
   logic [DATA_W-1:0]   r_win     [3][3];
   logic [DATA_W-1:0]   w_win_nxt [3][3];
   logic [9*DATA_W-1:0] w_win_pack;

   logic                w_adv;
   logic                w_consume;
   logic                w_last_pix;
   logic                w_stride_ok;
   logic                w_emit;
   logic [c_CW-1:0]     w_lb_idx;

   assign busy     = (r_state != ST_IDLE);
   assign mem_addr = r_rd_addr[ADDR_W-1:0];
   assign w_lb_idx = r_col[c_CW-1:0];

   // Datapath control: read issue, pixel consumption and window emission
   always_comb begin
      w_adv      = !win_valid || win_ready;
      w_consume  = (r_state == ST_SCAN) && r_rd_v && w_adv;
      mem_re     = (r_state == ST_SCAN) && (r_rd_addr < c_TOTAL) && (!r_rd_v || w_adv);
      w_last_pix = w_consume && (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
`ifdef IMG_WIN_STRIDE2_EN
      // (r-2) and (c-2) even is the same as r and c even
      w_stride_ok = !r_row[0] && !r_col[0];
`else
      w_stride_ok = 1'b1;
`endif
      w_emit = w_consume && (r_row >= 16'd2) && (r_col >= 16'd2) && w_stride_ok;
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 2; j++) begin
            w_win_nxt[i][j] = r_win[i][j+1];
         end
      end
      w_win_nxt[0][2] = r_lb1[w_lb_idx];
      w_win_nxt[1][2] = r_lb0[w_lb_idx];
      w_win_nxt[2][2] = mem_rdata;
      w_win_pack = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w_win_pack[(8 - (i*3 + j))*DATA_W +: DATA_W] = w_win_nxt[i][j];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_SCAN;
         end
         ST_SCAN: begin
            if (w_last_pix) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!win_valid || win_ready) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         done      <= 1'b0;
         r_rd_addr <= '0;
         r_rd_v    <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
         win_valid <= 1'b0;
         win_data  <= '0;
         win_row   <= '0;
         win_col   <= '0;
      end else begin
         r_state <= w_state_nxt;
         done    <= w_done_nxt;
         if (r_state == ST_IDLE && start) begin
            r_rd_addr <= '0;
            r_rd_v    <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
         end else begin
            if (mem_re) r_rd_addr <= r_rd_addr + 1'b1;
            // A stalled pixel stays pending: the page holds its data_out
            r_rd_v <= mem_re || (r_rd_v && !w_adv);
            if (w_consume) begin
               if (r_col == c_LAST_COL) begin
                  r_col <= '0;
                  r_row <= r_row + 16'd1;
               end else begin
                  r_col <= r_col + 16'd1;
               end
            end
         end
         if (w_emit) begin
            win_valid <= 1'b1;
            win_data  <= w_win_pack;
            win_row   <= r_row - 16'd1;
            win_col   <= r_col - 16'd1;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

   // Line buffers and shift array need no reset: three shifts refill the array
   always_ff @(posedge clk) begin
      if (w_consume) begin
         r_win           <= w_win_nxt;
         r_lb1[w_lb_idx] <= r_lb0[w_lb_idx];
         r_lb0[w_lb_idx] <= mem_rdata;
      end
   end

endmodule
`default_nettype wire
